// File: rtl/cpu_mem_pkg.sv
// Shared types and helpers for the CPU memory responder.
package cpu_mem_pkg;

    localparam int          WORD_WIDTH = 32;
    localparam logic [31:0] ALIGN_MASK = 32'h0000_0003;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        ACCESS  = 2'd2,
        RESPOND = 2'd3
    } state_e;

    // True when addr is word aligned and falls inside [base, base + span_bytes).
    function automatic logic addr_in_range(input logic [31:0] addr,
                                           input logic [31:0] base,
                                           input logic [32:0] span_bytes);
        logic [31:0] off;
        off = addr - base;
        return ((addr & ALIGN_MASK) == 32'h0000_0000) &&
               (addr >= base) &&
               ({1'b0, off} < span_bytes);
    endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous word RAM; a write cycle leaves the read register untouched.
module mem_array
    import cpu_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [ADDR_W-1:0]     addr_i,
    input  logic [WORD_WIDTH-1:0] wdata_i,
    output logic [WORD_WIDTH-1:0] rdata_o
);

    logic [WORD_WIDTH-1:0] mem_q [DEPTH_WORDS];
    logic [WORD_WIDTH-1:0] rdata_q;

    // Storage and registered read port; contents deliberately have no reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end else begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// CPU-facing memory responder: request latch, wait-state FSM, range check and
// preload port sharing one RAM port.
module mem_responder
    import cpu_mem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_STATES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_req,
    input  logic        in_write_en,
    input  logic [31:0] in_address,
    input  logic [31:0] in_write_data,
    output logic [31:0] out_read_data,
    output logic        out_ready,
    output logic        out_fault,
    output logic        out_busy,
    input  logic        load_en,
    input  logic [31:0] load_address,
    input  logic [31:0] load_data
);

    localparam int          IDX_W      = $clog2(DEPTH_WORDS);
    localparam logic [32:0] SPAN_BYTES = 33'(DEPTH_WORDS) * 33'd4;
    localparam logic [3:0]  WAIT_LOAD  = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        wr_q, wr_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        fault_q, fault_d;
    logic        ready_q, ready_d;
    logic        fault_out_q, fault_out_d;
    logic        busy_q, busy_d;

    logic             req_ok_s;
    logic             load_ok_s;
    logic             ram_we_s;
    logic [IDX_W-1:0] ram_addr_s;
    logic [31:0]      ram_wdata_s;
    logic [31:0]      ram_rdata_s;

    assign req_ok_s  = addr_in_range(in_address, BASE_ADDR, SPAN_BYTES);
    assign load_ok_s = load_en && !in_req && (state_q == IDLE) &&
                       addr_in_range(load_address, BASE_ADDR, SPAN_BYTES);

    // RAM port mux: an accepted preload owns the port, otherwise the latched request does.
    always_comb begin
        ram_we_s    = 1'b0;
        ram_addr_s  = IDX_W'((addr_q - BASE_ADDR) >> 2);
        ram_wdata_s = wdata_q;
        if (load_ok_s) begin
            ram_we_s    = !reset;
            ram_addr_s  = IDX_W'((load_address - BASE_ADDR) >> 2);
            ram_wdata_s = load_data;
        end else begin
            ram_we_s    = (state_q == ACCESS) && wr_q && !reset;
        end
    end

    mem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .ADDR_W      (IDX_W)
    ) u_mem_array (
        .clk     (clk),
        .we_i    (ram_we_s),
        .addr_i  (ram_addr_s),
        .wdata_i (ram_wdata_s),
        .rdata_o (ram_rdata_s)
    );

    // Next-state and response logic; outputs are registered from RESPOND.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wr_d        = wr_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        fault_d     = fault_q;
        ready_d     = 1'b0;
        fault_out_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_req) begin
                    wr_d    = in_write_en;
                    addr_d  = in_address;
                    wdata_d = in_write_data;
                    if (!req_ok_s) begin
                        fault_d = 1'b1;
                        state_d = RESPOND;
                    end else if (WAIT_STATES > 0) begin
                        fault_d = 1'b0;
                        cnt_d   = WAIT_LOAD;
                        state_d = WAIT;
                    end else begin
                        fault_d = 1'b0;
                        state_d = ACCESS;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ACCESS;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ACCESS: begin
                state_d = RESPOND;
            end
            RESPOND: begin
                ready_d     = 1'b1;
                fault_out_d = fault_q;
                if (!wr_q && !fault_q) begin
                    rdata_d = ram_rdata_s;
                end else begin
                    rdata_d = rdata_q;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            wr_q        <= 1'b0;
            addr_q      <= 32'h0000_0000;
            wdata_q     <= 32'h0000_0000;
            rdata_q     <= 32'h0000_0000;
            fault_q     <= 1'b0;
            ready_q     <= 1'b0;
            fault_out_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            fault_q     <= fault_d;
            ready_q     <= ready_d;
            fault_out_q <= fault_out_d;
            busy_q      <= busy_d;
        end
    end

    assign out_read_data = rdata_q;
    assign out_ready     = ready_q;
    assign out_fault     = fault_out_q;
    assign out_busy      = busy_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: one instance with one wait state, one with none,
// both checked against an address-indexed word model.
module tb_mem_responder;

    localparam int          DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst     [2];
    logic        req     [2];
    logic        we      [2];
    logic [31:0] addr    [2];
    logic [31:0] wd      [2];
    logic [31:0] rdata   [2];
    logic        rdy     [2];
    logic        flt     [2];
    logic        busy    [2];
    logic        ld_en   [2];
    logic [31:0] ld_addr [2];
    logic [31:0] ld_data [2];

    int          ws     [2];
    logic [31:0] exp_rd [2];
    logic [31:0] mdl    [int];
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(1), .BASE_ADDR(BASE)) u_a (
        .clk(clk), .reset(rst[0]), .in_req(req[0]), .in_write_en(we[0]),
        .in_address(addr[0]), .in_write_data(wd[0]), .out_read_data(rdata[0]),
        .out_ready(rdy[0]), .out_fault(flt[0]), .out_busy(busy[0]),
        .load_en(ld_en[0]), .load_address(ld_addr[0]), .load_data(ld_data[0]));

    mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(0), .BASE_ADDR(BASE)) u_b (
        .clk(clk), .reset(rst[1]), .in_req(req[1]), .in_write_en(we[1]),
        .in_address(addr[1]), .in_write_data(wd[1]), .out_read_data(rdata[1]),
        .out_ready(rdy[1]), .out_fault(flt[1]), .out_busy(busy[1]),
        .load_en(ld_en[1]), .load_address(ld_addr[1]), .load_data(ld_data[1]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic bit addr_ok(input logic [31:0] a);
        longint la;
        la = longint'(a);
        return (a % 4 == 0) && (la >= longint'(BASE)) && (la < longint'(BASE) + 4 * DEPTH);
    endfunction

    function automatic int key(input int k, input logic [31:0] a);
        return k * 65536 + int'((a - BASE) / 4);
    endfunction

    task automatic load(input int k, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        ld_en[k] = 1'b1; ld_addr[k] = a; ld_data[k] = d;
        @(negedge clk);
        ld_en[k] = 1'b0;
        if (addr_ok(a)) mdl[key(k, a)] = d;
    endtask

    // One request; watches 12 cycles for latency, pulse count, busy window and payload.
    task automatic xact(input int k, input bit wr, input logic [31:0] a,
                        input logic [31:0] d, input bit poke);
        bit          ok;
        int          lat, first_c, pulses, busy_bad;
        logic        saw_f;
        logic [31:0] saw_d;
        ok = addr_ok(a);
        lat = ok ? ws[k] + 2 : 1;
        first_c = -1; pulses = 0; busy_bad = 0; saw_f = 1'b0; saw_d = 32'h0;
        @(negedge clk);
        req[k] = 1'b1; we[k] = wr; addr[k] = a; wd[k] = d;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            req[k] = 1'b0; ld_en[k] = 1'b0;
            if (rdy[k] === 1'b1) begin
                pulses++;
                if (first_c < 0) begin
                    first_c = c; saw_f = flt[k]; saw_d = rdata[k];
                end
            end
            if (busy[k] !== (c < lat)) busy_bad++;
            if (poke && (c == 0 || c == lat - 1)) begin
                req[k] = 1'b1; we[k] = 1'b1; addr[k] = 32'h40; wd[k] = 32'h5555_AAAA;
                if (c == 0) begin
                    ld_en[k] = 1'b1; ld_addr[k] = 32'h44; ld_data[k] = 32'h6666_9999;
                end
            end
        end
        if (ok && wr) mdl[key(k, a)] = d;
        if (ok && !wr) exp_rd[k] = mdl[key(k, a)];
        chk($sformatf("latency[%0d] a=%h", k, a), 32'(first_c), 32'(lat));
        chk($sformatf("pulses[%0d] a=%h", k, a), 32'(pulses), 32'd1);
        chk($sformatf("busy_window[%0d] a=%h", k, a), 32'(busy_bad), 32'd0);
        chk($sformatf("fault[%0d] a=%h", k, a), 32'(saw_f), 32'(!ok));
        chk($sformatf("rdata[%0d] a=%h", k, a), saw_d, exp_rd[k]);
    endtask

    initial begin
        logic [31:0] a, d;
        int          bb_bad;
        ws[0] = 1; ws[1] = 0;
        for (int k = 0; k < 2; k++) begin
            rst[k] = 1'b1; req[k] = 1'b0; we[k] = 1'b0; addr[k] = 32'h0; wd[k] = 32'h0;
            ld_en[k] = 1'b0; ld_addr[k] = 32'h0; ld_data[k] = 32'h0; exp_rd[k] = 32'h0;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("reset_ready[%0d]", k), 32'(rdy[k]), 32'd0);
            chk($sformatf("reset_fault[%0d]", k), 32'(flt[k]), 32'd0);
            chk($sformatf("reset_busy[%0d]", k), 32'(busy[k]), 32'd0);
            chk($sformatf("reset_rdata[%0d]", k), rdata[k], 32'h0);
        end
        rst[0] = 1'b0; rst[1] = 1'b0;

        // Preload a known window so every later in-range read has a defined answer.
        for (int k = 0; k < 2; k++) begin
            for (int w = 0; w < 64; w++) load(k, 32'(w) * 32'd4, $urandom);
            load(k, 32'h10, 32'hE1A0_0000);
        end

        for (int k = 0; k < 2; k++) begin
            xact(k, 1'b0, 32'h10, 32'h0, 1'b0);
            xact(k, 1'b1, 32'h20, 32'hDEAD_BEEF, 1'b0);
            xact(k, 1'b0, 32'h20, 32'h0, 1'b0);
            xact(k, 1'b0, 32'h22, 32'h0, 1'b0);
            xact(k, 1'b0, 32'h1000, 32'h0, 1'b0);
            xact(k, 1'b1, 32'h1000, 32'h1234_5678, 1'b0);
            xact(k, 1'b0, 32'h0, 32'h0, 1'b0);
            // Dropped loads: out of range aliasing word 4, and misaligned into word 4.
            load(k, 32'h1010, 32'hBAD0_0001);
            load(k, 32'h12, 32'hBAD0_0002);
            xact(k, 1'b0, 32'h10, 32'h0, 1'b0);
            xact(k, 1'b0, 32'h14, 32'h0, 1'b1);
            xact(k, 1'b0, 32'h40, 32'h0, 1'b0);
            xact(k, 1'b0, 32'h44, 32'h0, 1'b0);
            xact(k, 1'b1, 32'h48, 32'h1357_9BDF, 1'b1);
            xact(k, 1'b0, 32'h40, 32'h0, 1'b0);
            xact(k, 1'b0, 32'h44, 32'h0, 1'b0);
        end

        // Reset during WAIT on the one-wait-state instance drops the pending write.
        @(negedge clk);
        req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h30; wd[0] = 32'h0BAD_F00D;
        @(negedge clk);
        req[0] = 1'b0; rst[0] = 1'b1;
        @(negedge clk);
        rst[0] = 1'b0; exp_rd[0] = 32'h0;
        chk("midrst_ready", 32'(rdy[0]), 32'd0);
        chk("midrst_fault", 32'(flt[0]), 32'd0);
        chk("midrst_busy", 32'(busy[0]), 32'd0);
        chk("midrst_rdata", rdata[0], 32'h0);
        bb_bad = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (rdy[0] !== 1'b0) bb_bad++;
        end
        chk("midrst_no_pulse", 32'(bb_bad), 32'd0);
        xact(0, 1'b0, 32'h30, 32'h0, 1'b0);

        // Back-to-back reads every third edge on the zero-wait-state instance.
        bb_bad = 0;
        @(negedge clk);
        req[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'h0;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            if (rdy[1] !== ((c % 3 == 2) && (c / 3 < 4))) bb_bad++;
            if ((c % 3 == 2) && (c / 3 < 4))
                chk($sformatf("b2b_rdata[%0d]", c / 3), rdata[1], mdl[key(1, 32'(c / 3) * 32'd8)]);
            req[1] = ((c + 1) % 3 == 0) && ((c + 1) / 3 < 4);
            addr[1] = 32'((c + 1) / 3) * 32'd8;
        end
        exp_rd[1] = mdl[key(1, 32'd24)];
        chk("b2b_pulse_pattern", 32'(bb_bad), 32'd0);

        // Randomized traffic mixing loads, good accesses and rejected addresses.
        for (int i = 0; i < 40; i++) begin
            int k;
            k = i % 2;
            if ($urandom_range(0, 9) < 2) begin
                case ($urandom_range(0, 2))
                    0:       a = (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(1, 3));
                    1:       a = 32'h0000_1000 + (32'($urandom_range(0, 63)) << 2);
                    default: a = 32'hFFFF_FFFC;
                endcase
            end else begin
                a = 32'($urandom_range(0, 63)) << 2;
            end
            d = $urandom;
            if ($urandom_range(0, 4) == 0) load(k, a, d);
            else xact(k, 1'($urandom_range(0, 1)), a, d, 1'($urandom_range(0, 1)));
        end
        for (int k = 0; k < 2; k++) xact(k, 1'b0, 32'h10, 32'h0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
